// File: rtl/timer_digit_entry.sv
// timer_digit_entry
//   Keypad front end for the oven timer. Debounces a one-hot ten-key pad,
//   shifts accepted digits in from the right (1,2,3 -> 1:23) and, on a start
//   request, presents the entered time as BCD to the three down-counters'
//   parallel-load inputs together with a one-cycle active-low load strobe.
//
// Ports
//   clk          in   system clock, all state on the rising edge
//   clear        in   synchronous active-high reset, overrides everything
//   keys[9:0]    in   raw key lines, bit n high = digit n pressed
//   enable_entry in   oven idle; key entry and commit allowed only when high
//   cancel       in   clears the entered digits, aborts a pending load
//   commit       in   start request
//   sec_ones     out  BCD seconds units
//   sec_tens     out  BCD tens of seconds
//   minutes      out  BCD minutes
//   load_n       out  active-low parallel-load strobe, low for one cycle
//   valid        out  entered time is loadable
//   digit_count  out  digits entered, 0..3
//   key_error    out  one-cycle pulse on a rejected key or commit
//
// Handshake: there is no back-pressure. A commit is taken at an edge where
// enable_entry, valid and load_n are all high; load_n is then low for exactly
// the following cycle while the digit outputs stay stable, and the digits
// clear at the edge that ends that cycle.

module timer_digit_entry #(
    parameter int KEY_HOLD = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] keys,
    input  logic       enable_entry,
    input  logic       cancel,
    input  logic       commit,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] minutes,
    output logic       load_n,
    output logic       valid,
    output logic [1:0] digit_count,
    output logic       key_error
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    localparam logic [3:0] HOLD_TGT = 4'(KEY_HOLD);

    logic [1:0] state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] ones_q, ones_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] mins_q, mins_d;
    logic [1:0] count_q, count_d;
    logic       load_n_q, load_n_d;
    logic       err_q, err_d;

    logic       key_none;
    logic       key_single;
    logic       key_multi;
    logic [3:0] key_idx;
    logic       accept;
    logic       reject_key;

    // Key pattern classification.
    always_comb begin
        key_none   = (keys == 10'd0);
        key_single = ($countones(keys) == 1);
        key_multi  = !key_none && !key_single;
        key_idx    = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) key_idx = 4'(i);
        end
    end

    // Debounce FSM. accept is high at the edge where the key has been seen
    // on KEY_HOLD consecutive edges; the digit itself is key_idx.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        idx_d      = idx_q;
        accept     = 1'b0;
        reject_key = 1'b0;
        if (!enable_entry) begin
            state_d = ST_IDLE;
            hold_d  = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (key_single) begin
                        idx_d = key_idx;
                        if (HOLD_TGT == 4'd1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            hold_d  = 4'd1;
                            state_d = ST_DEBOUNCE;
                        end
                    end else if (key_multi) begin
                        reject_key = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (key_single && (key_idx == idx_q)) begin
                        if (hold_q + 4'd1 == HOLD_TGT) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            hold_d = hold_q + 4'd1;
                        end
                    end else begin
                        // Bounce, release or a second key: start over quietly.
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (key_none) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign valid = (count_q != 2'd0)
                && ({mins_q, tens_q, ones_q} != 12'd0)
                && (tens_q <= 4'd5);

    // Digit register / load strobe. Priority: load completion or cancel,
    // then commit, then digit acceptance. An acceptance that loses to a
    // commit, a cancel or an in-flight load is simply consumed.
    always_comb begin
        ones_d   = ones_q;
        tens_d   = tens_q;
        mins_d   = mins_q;
        count_d  = count_q;
        load_n_d = load_n_q;
        err_d    = reject_key;
        if (cancel || !load_n_q) begin
            ones_d   = 4'd0;
            tens_d   = 4'd0;
            mins_d   = 4'd0;
            count_d  = 2'd0;
            load_n_d = 1'b1;
        end else if (enable_entry && commit) begin
            if (valid) load_n_d = 1'b0;
            else       err_d    = 1'b1;
        end else if (accept) begin
            if (count_q != 2'd3) begin
                mins_d  = tens_q;
                tens_d  = ones_q;
                ones_d  = key_idx;
                count_d = count_q + 2'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= ST_IDLE;
            hold_q   <= 4'd0;
            idx_q    <= 4'd0;
            ones_q   <= 4'd0;
            tens_q   <= 4'd0;
            mins_q   <= 4'd0;
            count_q  <= 2'd0;
            load_n_q <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            idx_q    <= idx_d;
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            mins_q   <= mins_d;
            count_q  <= count_d;
            load_n_q <= load_n_d;
            err_q    <= err_d;
        end
    end

    assign sec_ones    = ones_q;
    assign sec_tens    = tens_q;
    assign minutes     = mins_q;
    assign digit_count = count_q;
    assign load_n      = load_n_q;
    assign key_error   = err_q;

endmodule

// File: tb/tb_timer_digit_entry.sv
module tb_timer_digit_entry;

    localparam int KEY_HOLD = 2;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] keys = '0;
    logic       enable_entry = 1'b0;
    logic       cancel = 1'b0;
    logic       commit = 1'b0;
    logic [3:0] sec_ones, sec_tens, minutes;
    logic       load_n, valid, key_error;
    logic [1:0] digit_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timer_digit_entry #(.KEY_HOLD(KEY_HOLD)) dut (
        .clk(clk), .clear(clear), .keys(keys), .enable_entry(enable_entry),
        .cancel(cancel), .commit(commit), .sec_ones(sec_ones),
        .sec_tens(sec_tens), .minutes(minutes), .load_n(load_n),
        .valid(valid), .digit_count(digit_count), .key_error(key_error)
    );

    // Reference model: entered digits as a list, plus the length of the
    // current run of one stable key and whether an accepted key is still down.
    int m_dig[$];
    bit m_lp;
    bit m_err;
    int m_run;
    int m_cur;
    bit m_held;

    function automatic int m_digit(int pos);
        if (m_dig.size() > pos) return m_dig[m_dig.size() - 1 - pos];
        return 0;
    endfunction

    function automatic bit m_valid();
        return (m_dig.size() != 0) &&
               (m_digit(0) + m_digit(1) + m_digit(2) != 0) &&
               (m_digit(1) <= 5);
    endfunction

    task automatic model_step(input logic [9:0] k, input logic en, input logic cn,
                              input logic cm, input logic cl);
        bit acc = 0;
        bit err = 0;
        int kidx = -1;
        bit single = ($countones(k) == 1);
        for (int i = 0; i < 10; i++) if (k[i]) kidx = i;
        if (cl) begin
            m_dig.delete();
            m_lp = 0; m_run = 0; m_held = 0; m_cur = 0; m_err = 0;
            return;
        end
        if (!en) begin
            m_run = 0; m_held = 0;
        end else if (m_held) begin
            if (k == 10'd0) m_held = 0;
        end else if (m_run == 0) begin
            if (single) begin
                m_cur = kidx; m_run = 1;
                if (m_run >= KEY_HOLD) acc = 1;
            end else if ($countones(k) >= 2) begin
                err = 1;
            end
        end else begin
            if (single && kidx == m_cur) begin
                m_run++;
                if (m_run >= KEY_HOLD) acc = 1;
            end else begin
                m_run = 0;
            end
        end
        if (acc) begin
            m_held = 1; m_run = 0;
        end
        if (m_lp || cn) begin
            m_dig.delete(); m_lp = 0;
        end else if (en && cm) begin
            if (m_valid()) m_lp = 1;
            else err = 1;
        end else if (acc) begin
            if (m_dig.size() < 3) m_dig.push_back(kidx);
            else err = 1;
        end
        m_err = err;
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic [9:0] k, input logic en, input logic cn,
                         input logic cm, input logic cl);
        keys = k; enable_entry = en; cancel = cn; commit = cm; clear = cl;
        model_step(k, en, cn, cm, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(10'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        cycle(10'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic press(input int d, input int n);
        logic [9:0] k;
        k = '0;
        k[d] = 1'b1;
        for (int i = 0; i < n; i++) cycle(k, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
    endtask

    task automatic test_reset();
        do_clear();
        n_cmp++; if (sec_ones !== 4'd0 || sec_tens !== 4'd0 || minutes !== 4'd0) begin
            n_bad++; $display("FAIL reset_digits got %0d%0d%0d want 000", minutes, sec_tens, sec_ones);
        end
        n_cmp++; if (digit_count !== 2'd0) begin
            n_bad++; $display("FAIL reset_count got %0d want 0", digit_count);
        end
        n_cmp++; if (load_n !== 1'b1 || key_error !== 1'b0 || valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_flags got load_n=%b err=%b valid=%b want 1 0 0", load_n, key_error, valid);
        end
    endtask

    task automatic test_entry();
        do_clear();
        press(1, 3); press(2, 3); press(3, 3);
        n_cmp++; if (minutes !== 4'd1 || sec_tens !== 4'd2 || sec_ones !== 4'd3) begin
            n_bad++; $display("FAIL entry_digits got %0d:%0d%0d want 1:23", minutes, sec_tens, sec_ones);
        end
        n_cmp++; if (digit_count !== 2'd3 || valid !== 1'b1) begin
            n_bad++; $display("FAIL entry_count got cnt=%0d valid=%b want 3 1", digit_count, valid);
        end
    endtask

    task automatic test_debounce();
        do_clear();
        press(5, 1); idle();
        n_cmp++; if (digit_count !== 2'd0 || sec_ones !== 4'd0) begin
            n_bad++; $display("FAIL glitch got cnt=%0d ones=%0d want 0 0", digit_count, sec_ones);
        end
        press(4, 10);
        n_cmp++; if (digit_count !== 2'd1 || sec_ones !== 4'd4 || sec_tens !== 4'd0) begin
            n_bad++; $display("FAIL hold_once got cnt=%0d tens=%0d ones=%0d want 1 0 4", digit_count, sec_tens, sec_ones);
        end
    endtask

    task automatic test_commit();
        do_clear();
        press(1, 3); press(2, 3); press(3, 3);
        cycle(10'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (load_n !== 1'b0) begin
            n_bad++; $display("FAIL commit_strobe got load_n=%b want 0", load_n);
        end
        n_cmp++; if (minutes !== 4'd1 || sec_tens !== 4'd2 || sec_ones !== 4'd3) begin
            n_bad++; $display("FAIL commit_hold got %0d:%0d%0d want 1:23", minutes, sec_tens, sec_ones);
        end
        idle();
        n_cmp++; if (load_n !== 1'b1 || valid !== 1'b0 || digit_count !== 2'd0) begin
            n_bad++; $display("FAIL commit_end got load_n=%b valid=%b cnt=%0d want 1 0 0", load_n, valid, digit_count);
        end
        n_cmp++; if ({minutes, sec_tens, sec_ones} !== 12'd0) begin
            n_bad++; $display("FAIL commit_clear got %0d:%0d%0d want 0:00", minutes, sec_tens, sec_ones);
        end
    endtask

    task automatic test_bad_commit();
        do_clear();
        press(7, 3); press(5, 3);
        n_cmp++; if (valid !== 1'b0 || sec_tens !== 4'd7 || sec_ones !== 4'd5) begin
            n_bad++; $display("FAIL tens7_valid got valid=%b tens=%0d ones=%0d want 0 7 5", valid, sec_tens, sec_ones);
        end
        cycle(10'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (key_error !== 1'b1 || load_n !== 1'b1) begin
            n_bad++; $display("FAIL bad_commit got err=%b load_n=%b want 1 1", key_error, load_n);
        end
        idle();
        n_cmp++; if (key_error !== 1'b0 || load_n !== 1'b1 || digit_count !== 2'd2) begin
            n_bad++; $display("FAIL bad_commit_after got err=%b load_n=%b cnt=%0d want 0 1 2", key_error, load_n, digit_count);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        press(1, 3); press(2, 3); press(3, 3);
        cycle(10'h010, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(10'h010, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (key_error !== 1'b1 || sec_ones !== 4'd3 || digit_count !== 2'd3) begin
            n_bad++; $display("FAIL fourth_digit got err=%b ones=%0d cnt=%0d want 1 3 3", key_error, sec_ones, digit_count);
        end
        cycle(10'h010, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (key_error !== 1'b0) begin
            n_bad++; $display("FAIL err_one_cycle got err=%b want 0", key_error);
        end
        idle();
        cycle(10'h003, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (key_error !== 1'b1 || sec_ones !== 4'd3 || minutes !== 4'd1) begin
            n_bad++; $display("FAIL multi_key got err=%b ones=%0d mins=%0d want 1 3 1", key_error, sec_ones, minutes);
        end
        idle();
    endtask

    task automatic test_cancel_clear();
        do_clear();
        press(1, 3); press(2, 3);
        cycle(10'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (load_n !== 1'b1 || digit_count !== 2'd0 || {minutes, sec_tens, sec_ones} !== 12'd0) begin
            n_bad++; $display("FAIL cancel_commit got load_n=%b cnt=%0d digits=%h want 1 0 000", load_n, digit_count, {minutes, sec_tens, sec_ones});
        end
        press(1, 3); press(2, 3);
        cycle(10'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        n_cmp++; if (load_n !== 1'b0) begin
            n_bad++; $display("FAIL load_before_clear got load_n=%b want 0", load_n);
        end
        do_clear();
        n_cmp++; if (load_n !== 1'b1 || digit_count !== 2'd0 || key_error !== 1'b0 || {minutes, sec_tens, sec_ones} !== 12'd0) begin
            n_bad++; $display("FAIL clear_during_load got load_n=%b cnt=%0d err=%b digits=%h want 1 0 0 000", load_n, digit_count, key_error, {minutes, sec_tens, sec_ones});
        end
    endtask

    task automatic test_random();
        logic [9:0] seg_k;
        int seg_left;
        logic en, cn, cm, cl;
        seg_k = '0;
        seg_left = 0;
        do_clear();
        for (int c = 0; c < 3000; c++) begin
            if (seg_left == 0) begin
                int r, a, b;
                r = $urandom_range(0, 9);
                seg_k = '0;
                if (r >= 4 && r <= 8) begin
                    seg_k[$urandom_range(0, 9)] = 1'b1;
                end else if (r == 9) begin
                    a = $urandom_range(0, 9);
                    b = (a + $urandom_range(1, 9)) % 10;
                    seg_k[a] = 1'b1;
                    seg_k[b] = 1'b1;
                end
                seg_left = $urandom_range(1, 4);
            end
            seg_left--;
            en = ($urandom_range(0, 19) != 0);
            cn = ($urandom_range(0, 39) == 0);
            cm = ($urandom_range(0, 9) == 0);
            cl = ($urandom_range(0, 199) == 0);
            cycle(seg_k, en, cn, cm, cl);
            n_cmp++; if (sec_ones !== 4'(m_digit(0))) begin
                n_bad++; $display("FAIL rnd_ones cyc %0d got %0d want %0d", c, sec_ones, m_digit(0));
            end
            n_cmp++; if (sec_tens !== 4'(m_digit(1))) begin
                n_bad++; $display("FAIL rnd_tens cyc %0d got %0d want %0d", c, sec_tens, m_digit(1));
            end
            n_cmp++; if (minutes !== 4'(m_digit(2))) begin
                n_bad++; $display("FAIL rnd_mins cyc %0d got %0d want %0d", c, minutes, m_digit(2));
            end
            n_cmp++; if (digit_count !== 2'(m_dig.size())) begin
                n_bad++; $display("FAIL rnd_count cyc %0d got %0d want %0d", c, digit_count, m_dig.size());
            end
            n_cmp++; if (load_n !== !m_lp) begin
                n_bad++; $display("FAIL rnd_load_n cyc %0d got %b want %b", c, load_n, !m_lp);
            end
            n_cmp++; if (valid !== m_valid()) begin
                n_bad++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, valid, m_valid());
            end
            n_cmp++; if (key_error !== m_err) begin
                n_bad++; $display("FAIL rnd_key_error cyc %0d got %b want %b", c, key_error, m_err);
            end
        end
    endtask

    initial begin
        m_lp = 0; m_err = 0; m_run = 0; m_cur = 0; m_held = 0;
        test_reset();
        test_entry();
        test_debounce();
        test_commit();
        test_bad_commit();
        test_overflow();
        test_cancel_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_digit_entry.md
Name: timer_digit_entry

Overview:
Keypad front end for the oven timer, directly upstream of the seconds, tens-of-seconds and minutes down-counters. It debounces a one-hot digit keypad and shifts entered digits right-to-left, so pressing 1,2,3 yields 1:23. On start it drives the counters' parallel-load inputs with BCD values and issues a one-cycle active-low load strobe.

Parameters:
KEY_HOLD, 2, consecutive sampled cycles a single key must stay stable before it is accepted (1..15)

Ports:
clk  input  1  system clock, all state on rising edge
clear  input  1  reset; synchronous, active-high
keys  input  10  raw key lines; bit n high = digit n pressed
enable_entry  input  1  oven idle; key entry and commit permitted only when high
cancel  input  1  synchronous clear of entered digits
commit  input  1  start request; loads the entered time into the counters
sec_ones  output  4  BCD seconds units, to the seconds counter input_signal
sec_tens  output  4  BCD tens of seconds, to the mod-6 counter input_signal
minutes  output  4  BCD minutes, to the minutes counter input_signal
load_n  output  1  active-low parallel-load strobe to all three counters
valid  output  1  entered time is loadable
digit_count  output  2  digits entered, 0..3
key_error  output  1  one-cycle pulse on a rejected action

Behaviour:
- Reset (clear=1 at an edge): sec_ones=sec_tens=minutes=0, digit_count=0, load_n=1, key_error=0, FSM=IDLE. clear overrides every other input.
- Single key: keys has exactly one bit set. Zero bits means released. Two or more bits means invalid.
- Key FSM states: IDLE, DEBOUNCE, HELD.
  - IDLE: a single key at an edge captures its index, sets hold_cnt=1 and moves to DEBOUNCE. An invalid pattern pulses key_error and stays in IDLE.
  - DEBOUNCE: the same key increments hold_cnt. A different key, release or invalid pattern returns to IDLE with no error.
  - Acceptance: at the edge where the key has been sampled on KEY_HOLD consecutive edges, accept it and go to HELD. With KEY_HOLD=1, IDLE accepts on the first edge and goes straight to HELD.
  - HELD: stay until keys==0 at an edge, then go to IDLE. A held key never repeats.
- Accepting a digit d: if digit_count<3, shift minutes<=sec_tens, sec_tens<=sec_ones, sec_ones<=d, digit_count+1. If digit_count==3, make no shift and pulse key_error.
- enable_entry=0: FSM is forced to IDLE and keys/commit are ignored. Digit registers hold their values.
- valid (combinational) = digit_count!=0 AND {minutes,sec_tens,sec_ones}!=0 AND sec_tens<=5.
- Commit:
  - With enable_entry=1, valid=1 and load_n=1 at edge t: load_n=0 for exactly the cycle after t, with the digit outputs held stable.
  - At the edge ending the load_n-low cycle: load_n returns to 1, digits clear to 0 and digit_count clears to 0.
  - Commit with valid=0 pulses key_error with no load. Commit while load_n=0 is ignored.
- Cancel: at the edge, digits and digit_count clear to 0 and any pending load_n low cycle is aborted (load_n=1).
- Priority at the same edge: clear > cancel > commit > digit acceptance.
  - An acceptance coinciding with a commit is consumed: FSM goes to HELD with no shift.
  - An acceptance coinciding with cancel is likewise consumed.
- key_error is registered, high for exactly one cycle per rejected event.
- Digits are always 0..9 by construction. sec_tens>5 is flagged only through valid=0; no saturation or correction.

Test Plan:
- KEY_HOLD=2. Press keys=0x002 for 3 cycles then release; repeat for 0x004 and 0x008 -> minutes=1, sec_tens=2, sec_ones=3, digit_count=3, valid=1.
- Key 5 high for 1 cycle then low -> no shift, digit_count stays 0. Hold 4 for 10 cycles -> exactly one shift, sec_ones=4.
- Entry 1,2,3 then commit one cycle -> load_n=0 exactly one cycle later with outputs 1/2/3 stable; next edge all digits 0 and valid=0.
- Enter 7,5 (tens=7) then commit -> valid=0, key_error one-cycle pulse, load_n stays 1.
- Fourth digit after three -> no shift, key_error pulse. keys=0x003 in IDLE -> key_error pulse, no shift.
- Commit and cancel at the same edge -> no load pulse, digits cleared. clear asserted during load_n low -> next cycle load_n=1, all outputs 0.
